// File: rtl/h264_pkg.sv
// Shared constants and helpers for the chroma DC quantiser.
package h264_pkg;

   // Forward quantiser multiplication factors for the DC position, indexed by qp%6
   localparam logic [13:0] MF_DC [6] = '{14'd13107, 14'd11916, 14'd10082,
                                         14'd9362,  14'd8192,  14'd7282};

   // qp -> {qp/6, qp%6}; an unrolled compare/subtract chain, so no divider is built.
   // Covers the full 6-bit range so out-of-range QP still yields a defined value.
   function automatic logic [6:0] qp_divmod6(input logic [5:0] qp);
      logic [3:0] qd;
      logic [5:0] rem;
      qd  = 4'd0;
      rem = qp;
      for (int i = 0; i < 10; i++) begin
         if (rem >= 6'd6) begin
            rem = rem - 6'd6;
            qd  = qd + 4'd1;
         end
      end
      return {qd, rem[2:0]};
   endfunction

endpackage

// File: rtl/h264dc_quantise_round.sv
// Final quantiser stage: add rounding offset, shift, saturate, restore sign.
module h264dc_quantise_round #(
   parameter int ZBITS = 12
) (
   input  logic [29:0]      prod,
   input  logic [4:0]       qbits,
   input  logic             sign,
   input  logic             intra,
   output logic [ZBITS-1:0] z
);

   localparam logic [39:0] ZMAX = 40'((1 << (ZBITS-1)) - 1);

   logic [39:0]      pow2;
   logic [39:0]      off2;
   logic [39:0]      sum;
   logic [39:0]      r;
   logic [ZBITS-1:0] mag;

   // Offset is floor(2^qbits/3 or /6) doubled; the extra shift bit compensates
   always_comb begin
      pow2 = 40'd1 << qbits;
      off2 = (intra ? (pow2 / 40'd3) : (pow2 / 40'd6)) << 1;
      sum  = {10'd0, prod} + off2;
      r    = sum >> ({1'b0, qbits} + 6'd1);
      mag  = (r > ZMAX) ? ZMAX[ZBITS-1:0] : r[ZBITS-1:0];
      z    = sign ? (~mag + 1'b1) : mag;
   end

endmodule

// File: rtl/h264dc_quantise.sv
// Chroma DC quantiser: 3-stage pipeline, 4 values per block, nonzero count per block.
module h264dc_quantise
   import h264_pkg::*;
#(
   parameter int ZBITS = 12
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [15:0]      YYIN,
   input  logic [5:0]       QP,
   input  logic             INTRA,
   output logic             READYI,
   output logic             VALID,
   output logic [ZBITS-1:0] ZOUT,
   output logic             LAST,
   output logic [2:0]       NZOUT,
   input  logic             READYO
);

   localparam int STAGES = 3;

   logic              adv;
   logic              take;
   logic [1:0]        cnt;
   logic [5:0]        qpl;
   logic              intral;
   logic [5:0]        qp_cur;
   logic              intra_cur;
   logic [6:0]        qdm;
   logic [STAGES:1]   vld_pipe;

   // S1
   logic              s1_sign;
   logic [15:0]       s1_mag;
   logic [3:0]        s1_qdiv;
   logic [2:0]        s1_qmod;
   logic              s1_last;
   logic              s1_intra;
   // S2
   logic [13:0]       mf;
   logic [29:0]       s2_prod;
   logic [4:0]        s2_qbits;
   logic              s2_sign;
   logic              s2_last;
   logic              s2_intra;
   // S3
   logic [ZBITS-1:0]  z;
   logic [2:0]        nz_acc;
   logic [2:0]        nz_sum;

   assign adv    = READYO;
   assign READYI = READYO;
   assign take   = ENABLE & adv;
   assign VALID  = vld_pipe[STAGES];

   // The first value of a block sees QP/INTRA directly; the rest use the latched copy
   assign qp_cur    = (cnt == 2'd0) ? QP : qpl;
   assign intra_cur = (cnt == 2'd0) ? INTRA : intral;
   assign qdm       = qp_divmod6(qp_cur);

   // Block position counter and per-block QP/INTRA latch
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt    <= 2'd0;
         qpl    <= 6'd0;
         intral <= 1'b0;
      end else if (take) begin
         cnt <= cnt + 2'd1;
         if (cnt == 2'd0) begin
            qpl    <= QP;
            intral <= INTRA;
         end
      end
   end

   // Stage-valid shift register; frozen while downstream stalls
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)    vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], take};
   end

   // S1: sign/magnitude split and qp divmod
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_sign  <= 1'b0;
         s1_mag   <= 16'd0;
         s1_qdiv  <= 4'd0;
         s1_qmod  <= 3'd0;
         s1_last  <= 1'b0;
         s1_intra <= 1'b0;
      end else if (take) begin
         s1_sign  <= YYIN[15];
         s1_mag   <= YYIN[15] ? (~YYIN + 16'd1) : YYIN;
         s1_qdiv  <= qdm[6:3];
         s1_qmod  <= qdm[2:0];
         s1_last  <= (cnt == 2'd3);
         s1_intra <= intra_cur;
      end
   end

   // MF table select by qp%6
   always_comb begin
      mf = MF_DC[0];
      case (s1_qmod)
         3'd1:    mf = MF_DC[1];
         3'd2:    mf = MF_DC[2];
         3'd3:    mf = MF_DC[3];
         3'd4:    mf = MF_DC[4];
         3'd5:    mf = MF_DC[5];
         default: mf = MF_DC[0];
      endcase
   end

   // S2: magnitude times MF, carry shift amount and flags
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s2_prod  <= 30'd0;
         s2_qbits <= 5'd0;
         s2_sign  <= 1'b0;
         s2_last  <= 1'b0;
         s2_intra <= 1'b0;
      end else if (adv && vld_pipe[1]) begin
         s2_prod  <= 30'(s1_mag) * 30'(mf);
         s2_qbits <= 5'd15 + {1'b0, s1_qdiv};
         s2_sign  <= s1_sign;
         s2_last  <= s1_last;
         s2_intra <= s1_intra;
      end
   end

   h264dc_quantise_round #(.ZBITS(ZBITS)) u_round (
      .prod  (s2_prod),
      .qbits (s2_qbits),
      .sign  (s2_sign),
      .intra (s2_intra),
      .z     (z)
   );

   assign nz_sum = nz_acc + {2'd0, |z};

   // S3: output register and per-block nonzero accumulation
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ZOUT   <= '0;
         LAST   <= 1'b0;
         NZOUT  <= 3'd0;
         nz_acc <= 3'd0;
      end else if (adv) begin
         LAST <= vld_pipe[2] & s2_last;
         if (vld_pipe[2]) begin
            ZOUT <= z;
            if (s2_last) begin
               NZOUT  <= nz_sum;
               nz_acc <= 3'd0;
            end else begin
               nz_acc <= nz_sum;
            end
         end
      end
   end

endmodule
